// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, false-start rejection and a FWFT receive FIFO.
// Define UART_RX_BREAK_DETECT_EN to add the break_det output and suppress pushing of break frames.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                          break_det
`endif
);

  localparam int unsigned RATE    = BAUD * OVERSAMPLE;
  localparam int unsigned DIV_RAW = 32'((64'(CLK_FREQ) + 64'(RATE) / 64'd2) / 64'(RATE));
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned S_W     = $clog2(OVERSAMPLE);
  localparam int unsigned B_W     = $clog2(DATA_BITS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned WORD_W  = DATA_BITS + 2;
  localparam int unsigned MID_LO  = OVERSAMPLE / 2 - 1;
  localparam int unsigned MID     = OVERSAMPLE / 2;
  localparam int unsigned MID_HI  = OVERSAMPLE / 2 + 1;
  localparam int unsigned LAST    = OVERSAMPLE - 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rx_sync, armed;
  logic [CNT_W-1:0]     tick_cnt;
  logic [S_W-1:0]       s;
  logic [B_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 v0, v1, parity_err, frame_err;
  logic                 tick, start_det, mid_hi_c, bit_c, last_stop_c, is_break_c, push_c, pop_c;
  logic                 full, wr_en, par_calc;
  logic [LVL_W-1:0]     level_nxt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [WORD_W-1:0]    mem [FIFO_DEPTH];
  logic [WORD_W-1:0]    head;

  // Two-flop synchroniser, idle-high after reset so no false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign start_det = (state == IDLE) && armed && !rx_sync;
  assign tick      = (tick_cnt == CNT_W'(DIV - 1));

  // Oversample tick; phase realigned to the detected start edge.
  always_ff @(posedge clk) begin
    if (rst || start_det || tick) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign mid_hi_c    = tick && (state != IDLE) && (s == S_W'(MID_HI));
  assign bit_c       = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
  assign last_stop_c = mid_hi_c && (state == STOP) && (bit_idx == B_W'(STOP_BITS - 1));
  assign par_calc    = (PARITY == 1) ? ~(^shreg) : ^shreg;
  assign push_c      = last_stop_c && !is_break_c;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      s          <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (tick && state != IDLE) begin
        if (s == S_W'(MID_LO)) v0 <= rx_sync;
        if (s == S_W'(MID))    v1 <= rx_sync;
        s <= (s == S_W'(LAST)) ? '0 : s + S_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (rx_sync) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (mid_hi_c && bit_c) state <= IDLE;
          else if (tick && s == S_W'(LAST)) begin
            state      <= DATA;
            bit_idx    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
          end
        end
        DATA: begin
          if (mid_hi_c) shreg <= {bit_c, shreg[DATA_BITS-1:1]};
          if (tick && s == S_W'(LAST)) begin
            if (bit_idx == B_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + B_W'(1);
            end
          end
        end
        PAR: begin
          if (mid_hi_c) parity_err <= (bit_c != par_calc);
          if (tick && s == S_W'(LAST)) begin
            bit_idx <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (mid_hi_c && !bit_c) frame_err <= 1'b1;
          // Last stop bit ends the frame at its mid-sample; the rest of the bit is not waited out.
          if (last_stop_c) begin
            state <= IDLE;
            armed <= bit_c;
          end else if (tick && s == S_W'(LAST)) begin
            bit_idx <= bit_idx + B_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_zero;

  // Tracks whether every data/parity/stop sample of this frame was 0.
  always_ff @(posedge clk) begin
    if (rst || state == START) all_zero <= 1'b1;
    else if (mid_hi_c && bit_c) all_zero <= 1'b0;
  end

  assign is_break_c = last_stop_c && all_zero && !bit_c;

  always_ff @(posedge clk) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= is_break_c;
  end
`else
  assign is_break_c = 1'b0;
`endif

  assign pop_c = rx_valid && rx_ready;
  assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign wr_en = push_c && (!full || pop_c);

  always_comb begin
    level_nxt = fifo_level;
    if (wr_en && !pop_c)      level_nxt = fifo_level + LVL_W'(1);
    else if (!wr_en && pop_c) level_nxt = fifo_level - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {frame_err | ~bit_c, parity_err, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_nxt;
      rx_valid   <= (level_nxt != '0);
      overrun    <= push_c && full && !pop_c;
    end
  end

  assign head = rx_valid ? mem[rd_ptr] : '0;
  assign {rx_frame_err, rx_parity_err, rx_data} = head;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 8N1 and 8E1 instances at DIV=1 (16 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int unsigned BIT_CLKS = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rx, rx_p, ready, ready_p;
  logic [7:0] data, data_p;
  logic       pe, fe, valid, ovr, busy;
  logic       pe_p, fe_p, valid_p, ovr_p, busy_p;
  logic [2:0] lvl, lvl_p;
  logic       brk;
  int         checks = 0, failures = 0, ovr_cnt = 0, brk_cnt = 0;
  exp_t       q[$];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(data), .rx_parity_err(pe), .rx_frame_err(fe),
    .rx_valid(valid), .rx_ready(ready), .overrun(ovr), .busy(busy), .fifo_level(lvl)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk)
`endif
  );

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_p;
`else
  assign brk = 1'b0;
`endif

  uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_data(data_p), .rx_parity_err(pe_p), .rx_frame_err(fe_p),
    .rx_valid(valid_p), .rx_ready(ready_p), .overrun(ovr_p), .busy(busy_p), .fifo_level(lvl_p)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_p)
`endif
  );

  always @(negedge clk) begin
    if (ovr === 1'b1) ovr_cnt++;
    if (brk === 1'b1) brk_cnt++;
  end

  // Expected word from the frame's bits.
  function automatic exp_t model(input logic [7:0] d, input int pmode, input logic pbit, input logic stop);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
    e.pe = (pmode == 0) ? 1'b0 : (pbit != ((pmode == 1) ? ~(^d) : ^d));
    return e;
  endfunction

  task automatic drive(input logic v, input bit on_p, input int ncyc);
    if (on_p) rx_p = v; else rx = v;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int pmode, input logic pbit, input logic stop, input bit on_p);
    logic [10:0] fr;
    int n;
    fr = '0;
    for (int i = 0; i < 8; i++) fr[i+1] = d[i];
    n = 9;
    if (pmode != 0) begin fr[n] = pbit; n++; end
    fr[n] = stop;
    n++;
    for (int i = 0; i < n; i++) drive(fr[i], on_p, BIT_CLKS);
  endtask

  task automatic pop_one(input bit on_p);
    if (on_p) ready_p = 1'b1; else ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    ready_p = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; ready = 1'b0; ready_p = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, data, pe, fe, ovr, busy, lvl} !== 15'd0) begin
      failures++; $display("FAIL reset_state: got %h expected 0", {valid, data, pe, fe, ovr, busy, lvl});
    end
    checks++;
    if ({valid_p, data_p, pe_p, fe_p, ovr_p, busy_p, lvl_p} !== 15'd0) begin
      failures++; $display("FAIL reset_state_p: got %h expected 0", {valid_p, data_p, pe_p, fe_p, ovr_p, busy_p, lvl_p});
    end
  endtask

  task automatic test_basic();
    send_frame(8'h56, 0, 1'b0, 1'b1, 0);
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, 8'h56, 2'b00, 3'd1}) begin
      failures++; $display("FAIL basic_head: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, 8'h56, 2'b00, 3'd1});
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({valid, data} !== {1'b1, 8'h56}) begin
      failures++; $display("FAIL basic_hold: got %h expected %h", {valid, data}, {1'b1, 8'h56});
    end
    pop_one(0);
    checks++;
    if ({valid, lvl} !== 4'd0) begin
      failures++; $display("FAIL basic_pop: got %h expected 0", {valid, lvl});
    end
  endtask

  task automatic test_parity();
    exp_t e;
    logic [7:0] d;
    logic pb;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin d = 8'hC9; pb = 1'b1; end
      else if (i == 1) begin d = 8'hC9; pb = 1'b0; end
      else begin d = 8'($urandom); pb = 1'($urandom); end
      e = model(d, 2, pb, 1'b1);
      send_frame(d, 2, pb, 1'b1, 1);
      checks++;
      if ({valid_p, data_p, pe_p, fe_p} !== {1'b1, e.d, e.pe, e.fe}) begin
        failures++; $display("FAIL parity_%0d: got %h expected %h", i, {valid_p, data_p, pe_p, fe_p}, {1'b1, e.d, e.pe, e.fe});
      end
      pop_one(1);
    end
  endtask

  task automatic test_false_start();
    exp_t e;
    drive(1'b0, 0, 4);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL false_start_busy: got %b expected 1", busy);
    end
    drive(1'b1, 0, 10);
    checks++;
    if ({busy, valid, lvl} !== 5'd0) begin
      failures++; $display("FAIL false_start_drop: got %h expected 0", {busy, valid, lvl});
    end
    drive(1'b1, 0, BIT_CLKS);
    e = model(8'hA5, 0, 1'b0, 1'b1);
    send_frame(8'hA5, 0, 1'b0, 1'b1, 0);
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, e.d, e.pe, e.fe, 3'd1}) begin
      failures++; $display("FAIL false_start_next: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, e.d, e.pe, e.fe, 3'd1});
    end
    pop_one(0);
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, BIT_CLKS);
      checks++;
      if ({busy, lvl} !== 4'd1) begin
        failures++; $display("FAIL frame_err_rearm_%0d: got %h expected 1", i, {busy, lvl});
      end
    end
    drive(1'b1, 0, BIT_CLKS);
    send_frame(8'h81, 0, 1'b0, 1'b1, 0);
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, 8'h3C, 2'b01, 3'd2}) begin
      failures++; $display("FAIL frame_err_word: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, 8'h3C, 2'b01, 3'd2});
    end
    pop_one(0);
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, 8'h81, 2'b00, 3'd1}) begin
      failures++; $display("FAIL frame_err_next: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, 8'h81, 2'b00, 3'd1});
    end
    pop_one(0);
  endtask

  task automatic test_overrun();
    exp_t e;
    int ovr0, exp_ovr;
    logic [7:0] d;
    ovr0 = ovr_cnt;
    exp_ovr = 0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      if (q.size() == 4) exp_ovr++; else q.push_back(model(d, 0, 1'b0, 1'b1));
      send_frame(d, 0, 1'b0, 1'b1, 0);
    end
    checks++;
    if (lvl !== 3'd4 || (ovr_cnt - ovr0) != exp_ovr) begin
      failures++; $display("FAIL overrun_fill: got lvl=%0d ovr=%0d expected lvl=4 ovr=%0d", lvl, ovr_cnt - ovr0, exp_ovr);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({valid, data, pe, fe} !== {1'b1, e.d, e.pe, e.fe}) begin
        failures++; $display("FAIL overrun_read: got %h expected %h", {valid, data, pe, fe}, {1'b1, e.d, e.pe, e.fe});
      end
      pop_one(0);
    end
    // Refill, then pop in the same clk as the fifth push (stop mid-sample).
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      q.push_back(model(d, 0, 1'b0, 1'b1));
      send_frame(d, 0, 1'b0, 1'b1, 0);
    end
    d = 8'($urandom);
    void'(q.pop_front());
    q.push_back(model(d, 0, 1'b0, 1'b1));
    fork
      send_frame(d, 0, 1'b0, 1'b1, 0);
      begin
        repeat (156) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    checks++;
    if (lvl !== 3'd4 || (ovr_cnt - ovr0) != exp_ovr) begin
      failures++; $display("FAIL overrun_pushpop: got lvl=%0d ovr=%0d expected lvl=4 ovr=%0d", lvl, ovr_cnt - ovr0, exp_ovr);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({valid, data, pe, fe} !== {1'b1, e.d, e.pe, e.fe}) begin
        failures++; $display("FAIL pushpop_read: got %h expected %h", {valid, data, pe, fe}, {1'b1, e.d, e.pe, e.fe});
      end
      pop_one(0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_frame(8'h5A, 0, 1'b0, 1'b1, 0);
    d = 8'h77;
    drive(1'b0, 0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(d[i], 0, BIT_CLKS);
    drive(d[4], 0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    checks++;
    if ({valid, data, pe, fe, ovr, busy, lvl} !== 15'd0) begin
      failures++; $display("FAIL reset_mid: got %h expected 0", {valid, data, pe, fe, ovr, busy, lvl});
    end
    drive(1'b1, 0, 2 * 10 * BIT_CLKS);
    checks++;
    if ({valid, busy, lvl} !== 5'd0) begin
      failures++; $display("FAIL reset_mid_nopush: got %h expected 0", {valid, busy, lvl});
    end
    send_frame(8'h12, 0, 1'b0, 1'b1, 0);
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, 8'h12, 2'b00, 3'd1}) begin
      failures++; $display("FAIL reset_mid_next: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, 8'h12, 2'b00, 3'd1});
    end
    pop_one(0);
  endtask

  task automatic test_break();
    int brk0;
    brk0 = brk_cnt;
    drive(1'b0, 0, 2 * 10 * BIT_CLKS);
    drive(1'b1, 0, 2 * BIT_CLKS);
`ifdef UART_RX_BREAK_DETECT_EN
    checks++;
    if (brk_cnt - brk0 != 1 || lvl !== 3'd0) begin
      failures++; $display("FAIL break: got pulses=%0d lvl=%0d expected pulses=1 lvl=0", brk_cnt - brk0, lvl);
    end
`else
    checks++;
    if ({valid, data, pe, fe, lvl} !== {1'b1, 8'h00, 2'b01, 3'd1} || brk_cnt != brk0) begin
      failures++; $display("FAIL break_word: got %h expected %h", {valid, data, pe, fe, lvl}, {1'b1, 8'h00, 2'b01, 3'd1});
    end
    pop_one(0);
`endif
  endtask

  task automatic test_random();
    exp_t e;
    logic [7:0] d;
    logic st;
    int brk0, exp_brk;
    brk0 = brk_cnt;
    exp_brk = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) begin
        d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        st = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_BREAK_DETECT_EN
        if (d == 8'h00 && !st) exp_brk++; else q.push_back(model(d, 0, 1'b0, st));
`else
        q.push_back(model(d, 0, 1'b0, st));
`endif
        send_frame(d, 0, 1'b0, st, 0);
        if (!st) drive(1'b1, 0, BIT_CLKS);
      end
      checks++;
      if (lvl !== 3'(q.size())) begin
        failures++; $display("FAIL random_level_%0d: got %0d expected %0d", b, lvl, q.size());
      end
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({valid, data, pe, fe} !== {1'b1, e.d, e.pe, e.fe}) begin
          failures++; $display("FAIL random_word: got %h expected %h", {valid, data, pe, fe}, {1'b1, e.d, e.pe, e.fe});
        end
        pop_one(0);
      end
    end
`ifdef UART_RX_BREAK_DETECT_EN
    checks++;
    if (brk_cnt - brk0 != exp_brk) begin
      failures++; $display("FAIL random_break: got %0d expected %0d", brk_cnt - brk0, exp_brk);
    end
`endif
    checks++;
    if ({valid, busy, lvl} !== 5'd0) begin
      failures++; $display("FAIL random_drained: got %h expected 0", {valid, busy, lvl});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_break();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. It is the successor to the fixed 8N1 receive path behind uart_top. It adds:
- configurable data bits, parity and stop bits
- majority-vote sampling
- false-start rejection
- per-word error flags
- a first-word-fall-through receive FIFO with a valid/ready handshake

It sits between the synchronised uart_RX pin and the consumer logic (echo TX path, seven-segment display, later the MIC-1 I/O port).

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  FIFO head data, LSB = first received bit
rx_parity_err  out  1  FIFO head parity error flag
rx_frame_err  out  1  FIFO head framing error flag
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts head; pop when rx_valid && rx_ready
overrun  out  1  one-cycle pulse: completed word dropped, FIFO full
busy  out  1  frame reception in progress (state != IDLE)
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored, 0..FIFO_DEPTH

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE, FIFO empty
  - rx_valid = 0, rx_data = 0, error flags = 0, overrun = 0, busy = 0, fifo_level = 0
  - 2-FF synchroniser and tick counter cleared; synchroniser flops reset to 1, so no false start after reset.
- Reset mid-frame aborts the frame; a partial word is never pushed.
- Tick generator:
  - DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), minimum 1.
  - Counter 0..DIV-1; tick for one clk when count == DIV-1.
  - Counter restarts on start-edge detection to align the phase.
- Sample counter s counts 0..OVERSAMPLE-1 per bit.
- Bit value = majority of the synced rx at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at the tick with s = OVERSAMPLE/2+1 ("mid-sample").
- State machine:
  - IDLE: armed only after synced rx has been seen 1 (flag `armed`). When armed and synced rx == 0, go to START.
  - START: at mid-sample, majority 1 means false start: go to IDLE, no push, armed stays 1. Majority 0 means wait to s = OVERSAMPLE-1, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, shifted into the shift register at each mid-sample. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: parity_err = (sampled bit != computed bit). Odd: XOR of data ^ 1. Even: XOR of data.
  - STOP: STOP_BITS bits, each sampled at mid-sample. Any 0 sets frame_err. At the mid-sample of the last stop bit:
    - push {frame_err, parity_err, data} in the same clk
    - go to IDLE immediately; the half stop bit is not waited out
    - armed = 0 if the sampled stop bit was 0, else 1
- Latency: rx_valid rises on the clk after the push clk when the FIFO was empty.
- FIFO:
  - First-word-fall-through, width DATA_BITS+2.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is the exact count.
  - Pop on rx_valid && rx_ready.
  - Push while full with no pop in the same clk: word discarded, overrun pulses one clk, FIFO contents unchanged.
  - Push and pop in the same clk while full: both succeed, no overrun, level unchanged.
  - Push and pop in the same clk while non-empty and not full: level unchanged.
- Outputs rx_data and the error flags show the head entry; they read 0 when the FIFO is empty.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- When defined:
  - Output port break_det (1 bit) exists.
  - A frame whose data bits, parity bit (if any) and stop bits all sample 0 is a break.
  - break_det pulses one clk at the last stop mid-sample. Nothing is pushed, overrun stays 0, armed = 0.
- When undefined:
  - Port absent.
  - Such a frame is pushed as data 0 with frame_err = 1 (and parity_err as computed).

Test Plan:
- Bench config for all scenarios: CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (DIV=1), 8N1 unless stated.
1. Send bits 0,1,1,0,1,0,1,0 (LSB first) with rx_ready=0 -> rx_valid=1, rx_data=0x56, both errors 0, level 1; rx_data held stable until rx_ready=1 for one clk, then rx_valid=0.
2. PARITY=2, send 0xC9 with parity bit 1 (correct is 0) -> rx_data=0xC9, rx_parity_err=1. Resend with parity bit 0 -> rx_parity_err=0.
3. Pull rx low for 4 ticks, then high -> no push, busy drops to 0 within 10 ticks. Following valid 0xA5 frame -> rx_data=0xA5.
4. Send 0x3C with stop bit 0, hold rx low 3 bit times, then high, then send 0x81 -> first word 0x3C with frame_err=1; no spurious start before rx returns high; second word 0x81 clean.
5. FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> fifo_level=4, overrun pulses exactly once at the 5th stop. Reads return 0x01..0x04 in order. Push and pop in the same clk while full -> level stays 4, no overrun.
6. Assert rst mid-DATA of 0x77 for one clk -> all outputs reset values next clk, nothing pushed; next frame 0x12 received correctly. Hold rx low for 2 frame times: with UART_RX_BREAK_DETECT_EN, break_det pulses once and level stays 0; without it, one word 0x00 with frame_err=1.
